// File: rtl/ro_mux_axil_slave_if.sv
// AXI4-Lite bus bundle between the VIP master and the ring-oscillator counter slave.
`timescale 1ns/1ps
interface ro_mux_axil_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ro_mux_axil_slave.sv
// AXI4-Lite slave that selects one ring oscillator, counts its rising edges over a
// programmable ACLK gate window and exposes CTRL/WINDOW/COUNT/STATUS registers.
`timescale 1ns/1ps
module ro_mux_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_RO             = 8,
    parameter int SEL_W              = 3
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    ro_mux_axil_slave_if.slave    s_axi,
    input  logic [NUM_RO-1:0]     ro_in,
    output logic                  ro_en,
    output logic [SEL_W-1:0]      ro_sel
);
    localparam int          STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [31:0] CTRL_MASK = 32'h4000_0000 | ((32'd1 << SEL_W) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic               awready_r, bvalid_r, arready_r, rvalid_r;
    logic [31:0]        rdata_r, rd_mux_s;
    logic [31:0]        ctrl_r, ctrl_new_s, window_r, count_r, gate_r, cnt_r, cnt_inc_s;
    logic               done_r, busy_s;
    logic [SEL_W-1:0]   ro_sel_r;
    logic [1:0]         sync_r;
    logic               prev_r, edge_s;
    logic               wr_fire_s, rd_fire_s, ctrl_wr_s, start_s, start_acc_s;
    logic [1:0]         wr_idx_s, rd_idx_s;
    logic               unused_s;

    // Byte-lane merge of a write into an existing register value.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [STRB_W-1:0] strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    assign wr_idx_s    = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign rd_idx_s    = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1 -: 2];
    assign wr_fire_s   = awready_r & s_axi.awvalid & s_axi.wvalid;
    assign rd_fire_s   = arready_r & s_axi.arvalid;
    assign ctrl_wr_s   = wr_fire_s && (wr_idx_s == 2'd0);
    assign ctrl_new_s  = apply_strb(ctrl_r, s_axi.wdata, s_axi.wstrb) & CTRL_MASK;
    assign start_s     = ctrl_wr_s && s_axi.wstrb[3] && s_axi.wdata[31];
    assign start_acc_s = start_s && (state_r == ST_IDLE);
    assign busy_s      = (state_r == ST_RUN);
    assign edge_s      = sync_r[1] & ~prev_r;
    assign unused_s    = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = awready_r;
    assign s_axi.wready  = awready_r;
    assign s_axi.bvalid  = bvalid_r;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready_r;
    assign s_axi.rvalid  = rvalid_r;
    assign s_axi.rdata   = rdata_r;
    assign s_axi.rresp   = 2'b00;
    assign ro_en         = ctrl_r[30];
    assign ro_sel        = ro_sel_r;

    // Write channel: AW/W accepted together only while no response is pending.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            awready_r <= ~awready_r & s_axi.awvalid & s_axi.wvalid & ~bvalid_r;
            if (wr_fire_s) begin
                bvalid_r <= 1'b1;
            end else if (s_axi.bready) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // RW register file; the start bit is never stored so CTRL[31] always reads 0.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ctrl_r   <= 32'd0;
            window_r <= 32'd0;
        end else begin
            if (ctrl_wr_s) begin
                ctrl_r <= ctrl_new_s;
            end
            if (wr_fire_s && (wr_idx_s == 2'd1)) begin
                window_r <= apply_strb(window_r, s_axi.wdata, s_axi.wstrb);
            end
        end
    end

    // Read data source; COUNT/STATUS are sampled before any capture on the same edge.
    always_comb begin
        rd_mux_s = 32'd0;
        case (rd_idx_s)
            2'd0:    rd_mux_s = ctrl_r;
            2'd1:    rd_mux_s = window_r;
            2'd2:    rd_mux_s = count_r;
            2'd3:    rd_mux_s = {30'd0, done_r, busy_s};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Read channel: one outstanding read, data held until RREADY.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            arready_r <= ~arready_r & s_axi.arvalid & ~rvalid_r;
            if (rd_fire_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_mux_s;
            end else if (s_axi.rready) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Synchroniser and edge detector; preloaded high on start so stale data from the
    // previously selected oscillator cannot produce a false edge.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            sync_r <= 2'b00;
            prev_r <= 1'b0;
        end else if (start_acc_s) begin
            sync_r <= 2'b11;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], ro_in[ro_sel_r]};
            prev_r <= sync_r[1];
        end
    end

    // Saturating edge counter increment.
    always_comb begin
        cnt_inc_s = cnt_r;
        if (edge_s && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_inc_s = cnt_r + 32'd1;
        end else begin
            cnt_inc_s = cnt_r;
        end
    end

    // Measurement state register.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a zero window skips RUN entirely.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = (window_r == 32'd0) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (gate_r == 32'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Gate/count datapath and result capture.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            ro_sel_r <= '0;
            gate_r   <= 32'd0;
            cnt_r    <= 32'd0;
            count_r  <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        ro_sel_r <= ctrl_new_s[SEL_W-1:0];
                        gate_r   <= window_r;
                        cnt_r    <= 32'd0;
                        done_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    gate_r <= gate_r - 32'd1;
                    cnt_r  <= cnt_inc_s;
                end
                ST_DONE: begin
                    count_r <= cnt_inc_s;
                    done_r  <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ro_mux_axil_slave.sv
// Directed bench for ro_mux_axil_slave: read expectations go through a scoreboard queue.
`timescale 1ns/1ps
module tb_ro_mux_axil_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ro2 = 1'b0;
    logic        ro5 = 1'b0;
    logic [7:0]  ro_in;
    logic        ro_en;
    logic [2:0]  ro_sel;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    ro_mux_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    ro_mux_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .NUM_RO(8), .SEL_W(3)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus),
        .ro_in(ro_in), .ro_en(ro_en), .ro_sel(ro_sel)
    );

    assign ro_in = {2'b00, ro5, 2'b00, ro2, 2'b00};

    always #5   clk = ~clk;
    always #40  ro2 = ~ro2;
    always #100 ro5 = ~ro5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int w_delay, input int b_hold);
        int n;
        bus.awaddr = a; bus.awvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
        for (int i = 0; i < w_delay; i++) begin
            tick();
            chk("aw_without_w_ready", {31'd0, bus.awready}, 32'd0);
        end
        bus.wvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 20) begin tick(); n++; end
        chk("aw_w_ready", {30'd0, bus.awready, bus.wready}, 32'd3);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("bvalid_rise", {31'd0, bus.bvalid}, 32'd1);
        for (int i = 0; i < b_hold; i++) begin
            tick();
            chk("bvalid_hold", {31'd0, bus.bvalid}, 32'd1);
        end
        chk("bresp", {30'd0, bus.bresp}, 32'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        chk("bvalid_clear", {31'd0, bus.bvalid}, 32'd0);
    endtask

    task automatic rd_raw(input logic [3:0] a, input int r_hold, output logic [31:0] d);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.arready !== 1'b1) chk("arready_timeout", {31'd0, bus.arready}, 32'd1);
        tick();
        bus.arvalid = 1'b0;
        n = 0;
        while (bus.rvalid !== 1'b1 && n < 20) begin tick(); n++; end
        if (bus.rvalid !== 1'b1) chk("rvalid_timeout", {31'd0, bus.rvalid}, 32'd1);
        for (int i = 0; i < r_hold; i++) begin
            tick();
            chk("rvalid_hold", {31'd0, bus.rvalid}, 32'd1);
            chk("rdata_hold", bus.rdata, exp_q[0]);
        end
        d = bus.rdata;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] expv,
                          input int r_hold);
        logic [31:0] d;
        exp_q.push_back(expv);
        rd_raw(a, r_hold, d);
        chk(tag, d, exp_q.pop_front());
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        d = 32'd0;
        for (int i = 0; i < 400; i++) begin
            rd_raw(4'hC, 0, d);
            if (d[1]) break;
        end
        chk(tag, {31'd0, d[1]}, 32'd1);
    endtask

    task automatic count_in(input string tag, input logic [31:0] lo, input logic [31:0] hi);
        logic [31:0] d;
        rd_raw(4'h8, 0, d);
        chk(tag, {31'd0, (d >= lo) && (d <= hi)}, 32'd1);
    endtask

    initial begin
        longint t0;
        bus.awaddr = 4'h0; bus.awprot = 3'd0; bus.awvalid = 1'b0;
        bus.wdata = 32'd0; bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = 4'h0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        repeat (20) tick();
        chk("reset_outputs", {20'd0, bus.awready, bus.wready, bus.bvalid, bus.arready,
            bus.rvalid, ro_en, ro_sel, bus.bresp == 2'b00 ? 1'b0 : 1'b1, 1'b0}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("reset_ctrl",   4'h0, 32'd0, 0);
        rd_chk("reset_window", 4'h4, 32'd0, 0);
        rd_chk("reset_count",  4'h8, 32'd0, 0);
        rd_chk("reset_status", 4'hC, 32'd0, 0);

        // Register read/write
        wr(4'h4, 32'h0000_0064, 4'hF, 0, 0);
        rd_chk("window_rw", 4'h4, 32'h0000_0064, 0);
        wr(4'h8, 32'h0000_DEAD, 4'hF, 0, 0);
        rd_chk("count_ro", 4'h8, 32'd0, 0);
        wr(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0);
        rd_chk("status_ro", 4'hC, 32'd0, 0);
        wr(4'h4, 32'hFFFF_FFFF, 4'b0001, 0, 0);
        rd_chk("window_wstrb", 4'h4, 32'h0000_00FF, 0);

        // Measurement of ro_in[2] (12.5 MHz) over 1000 cycles
        wr(4'h4, 32'd1000, 4'hF, 0, 0);
        wr(4'h0, 32'hC000_0002, 4'hF, 0, 0);
        t0 = $time;
        rd_chk("status_busy", 4'hC, 32'h0000_0001, 0);
        chk("ro_sel_2", {29'd0, ro_sel}, 32'd2);
        chk("ro_en_on", {31'd0, ro_en}, 32'd1);
        wait_done("done_ro2");
        chk("window_len", {31'd0, (($time - t0) / 10 >= 990) && (($time - t0) / 10 <= 1015)}, 32'd1);
        count_in("count_ro2", 32'd124, 32'd126);
        rd_chk("status_done", 4'hC, 32'h0000_0002, 0);
        rd_chk("ctrl_start_reads0", 4'h0, 32'h4000_0002, 0);

        // Zero window: immediate done with zero count
        wr(4'h4, 32'd0, 4'hF, 0, 0);
        wr(4'h0, 32'h8000_0005, 4'hF, 0, 0);
        rd_chk("zero_win_status", 4'hC, 32'h0000_0002, 0);
        rd_chk("zero_win_count", 4'h8, 32'd0, 0);
        chk("ro_sel_5", {29'd0, ro_sel}, 32'd5);
        chk("ro_en_off", {31'd0, ro_en}, 32'd0);

        // ro_in[5] (5 MHz) over 200 cycles
        wr(4'h4, 32'd200, 4'hF, 0, 0);
        wr(4'h0, 32'hC000_0005, 4'hF, 0, 0);
        wait_done("done_ro5");
        count_in("count_ro5", 32'd9, 32'd11);

        // Start while busy is ignored; new sel only stored in CTRL
        wr(4'h4, 32'd1000, 4'hF, 0, 0);
        wr(4'h0, 32'hC000_0002, 4'hF, 0, 0);
        t0 = $time;
        repeat (300) tick();
        wr(4'h0, 32'hC000_0003, 4'hF, 0, 0);
        chk("busy_start_sel_kept", {29'd0, ro_sel}, 32'd2);
        rd_chk("ctrl_rewritten", 4'h0, 32'h4000_0003, 0);
        rd_chk("still_busy", 4'hC, 32'h0000_0001, 0);
        wait_done("done_no_restart");
        chk("no_restart_len", {31'd0, (($time - t0) / 10 >= 990) && (($time - t0) / 10 <= 1015)}, 32'd1);
        count_in("count_first_window", 32'd124, 32'd126);

        // Reset in the middle of a run
        wr(4'h0, 32'hC000_0002, 4'hF, 0, 0);
        repeat (500) tick();
        rst = 1'b1;
        repeat (3) tick();
        chk("midrun_reset_pins", {28'd0, ro_en, ro_sel}, 32'd0);
        rst = 1'b0;
        tick();
        rd_chk("midrun_status", 4'hC, 32'd0, 0);
        rd_chk("midrun_count",  4'h8, 32'd0, 0);
        rd_chk("midrun_ctrl",   4'h0, 32'd0, 0);

        // Handshake stalls and split AW/W
        wr(4'h4, 32'h1234_5678, 4'hF, 3, 5);
        rd_chk("split_aw_w_rd_stall", 4'h4, 32'h1234_5678, 5);

        // Concurrent read and write
        fork
            wr(4'h4, 32'hA5A5_0001, 4'hF, 0, 0);
            rd_chk("concurrent_read", 4'h0, 32'd0, 0);
        join
        rd_chk("concurrent_write", 4'h4, 32'hA5A5_0001, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
